// File: rtl/ptw_walker.sv
// ptw_walker: two-level Sv32-style page-table walker.
// It takes one VPN from the TLB controller and walks the L1 and L0 tables
// through a single-outstanding PTE read port. It then returns the PPN,
// the {U,X,W,R} permissions, the page level and a fault flag.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   root_ppn_i                root table PPN, sampled when a request is accepted
//   ptw_req_*                 miss request from the TLB (valid/ready/vpn)
//   ptw_resp_*                walk result to the TLB (valid/ready/ppn/perm/super/fault)
//   mem_req_*                 PTE read request (valid/ready/addr)
//   mem_resp_*                PTE read data (valid/ready/data)
//
// Build option: define PTW_AD_CHECK_EN to report a leaf PTE with A=0 as a fault.
// When it is undefined, the A and D bits are ignored.
module ptw_walker #(
    parameter int VPN_WIDTH  = 20,
    parameter int PPN_WIDTH  = 20,
    parameter int PTE_WIDTH  = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PPN_WIDTH-1:0]  root_ppn_i,
    input  logic                  ptw_req_valid_i,
    output logic                  ptw_req_ready_o,
    input  logic [VPN_WIDTH-1:0]  ptw_req_vpn_i,
    output logic                  ptw_resp_valid_o,
    input  logic                  ptw_resp_ready_i,
    output logic [PPN_WIDTH-1:0]  ptw_resp_ppn_o,
    output logic [3:0]            ptw_resp_perm_o,
    output logic                  ptw_resp_super_o,
    output logic                  ptw_resp_fault_o,
    output logic                  mem_req_valid_o,
    input  logic                  mem_req_ready_i,
    output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
    input  logic                  mem_resp_valid_i,
    output logic                  mem_resp_ready_o,
    input  logic [PTE_WIDTH-1:0]  mem_resp_data_i
);
    localparam int IDX_W = 10;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_L1_REQ  = 3'd1;
    localparam logic [2:0] S_L1_WAIT = 3'd2;
    localparam logic [2:0] S_L0_REQ  = 3'd3;
    localparam logic [2:0] S_L0_WAIT = 3'd4;
    localparam logic [2:0] S_RESPOND = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [IDX_W-1:0]      vpn_lo_q, vpn_lo_d;
    logic                  req_ready_q, req_ready_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [PPN_WIDTH-1:0]  resp_ppn_q, resp_ppn_d;
    logic [3:0]            resp_perm_q, resp_perm_d;
    logic                  resp_super_q, resp_super_d;
    logic                  resp_fault_q, resp_fault_d;
    logic                  mem_req_valid_q, mem_req_valid_d;
    logic [ADDR_WIDTH-1:0] mem_req_addr_q, mem_req_addr_d;
    logic                  mem_resp_ready_q, mem_resp_ready_d;

    // PTE field decode of the incoming read data
    logic                 pte_v, pte_r, pte_w, pte_x;
    logic                 pte_bad, pte_leaf, pte_misaligned, ad_fault;
    logic [PPN_WIDTH-1:0] pte_ppn;
    logic [3:0]           pte_perm;
    logic                 l1_fault, l0_fault;
    logic                 unused_pte_bits;

    assign pte_v          = mem_resp_data_i[0];
    assign pte_r          = mem_resp_data_i[1];
    assign pte_w          = mem_resp_data_i[2];
    assign pte_x          = mem_resp_data_i[3];
    assign pte_perm       = mem_resp_data_i[4:1];
    assign pte_ppn        = mem_resp_data_i[PPN_WIDTH+9:10];
    assign pte_bad        = !pte_v || (pte_w && !pte_r);
    assign pte_leaf       = pte_r || pte_x;
    assign pte_misaligned = pte_ppn[IDX_W-1:0] != '0;
    assign unused_pte_bits = ^{mem_resp_data_i[PTE_WIDTH-1:PPN_WIDTH+10], mem_resp_data_i[9:5]};

`ifdef PTW_AD_CHECK_EN
    assign ad_fault = !mem_resp_data_i[6];
`else
    assign ad_fault = 1'b0;
`endif

    // Only reached for leaf or bad PTEs at L1; a non-leaf PTE descends instead.
    assign l1_fault = pte_bad || pte_misaligned || ad_fault;
    assign l0_fault = pte_bad || !pte_leaf || ad_fault;

    always_comb begin
        state_d          = state_q;
        vpn_lo_d         = vpn_lo_q;
        req_ready_d      = req_ready_q;
        resp_valid_d     = resp_valid_q;
        resp_ppn_d       = resp_ppn_q;
        resp_perm_d      = resp_perm_q;
        resp_super_d     = resp_super_q;
        resp_fault_d     = resp_fault_q;
        mem_req_valid_d  = mem_req_valid_q;
        mem_req_addr_d   = mem_req_addr_q;
        mem_resp_ready_d = mem_resp_ready_q;
        case (state_q)
            S_IDLE: begin
                if (ptw_req_valid_i && req_ready_q) begin
                    // The L1 address is formed now, so root_ppn_i needs no holding register.
                    vpn_lo_d        = ptw_req_vpn_i[IDX_W-1:0];
                    req_ready_d     = 1'b0;
                    mem_req_valid_d = 1'b1;
                    mem_req_addr_d  = {root_ppn_i, ptw_req_vpn_i[VPN_WIDTH-1:IDX_W], 2'b00};
                    state_d         = S_L1_REQ;
                end
            end
            S_L1_REQ, S_L0_REQ: begin
                if (mem_req_ready_i) begin
                    mem_req_valid_d  = 1'b0;
                    mem_resp_ready_d = 1'b1;
                    state_d          = (state_q == S_L1_REQ) ? S_L1_WAIT : S_L0_WAIT;
                end
            end
            S_L1_WAIT: begin
                if (mem_resp_valid_i) begin
                    mem_resp_ready_d = 1'b0;
                    if (!pte_bad && !pte_leaf) begin
                        mem_req_valid_d = 1'b1;
                        mem_req_addr_d  = {pte_ppn, vpn_lo_q, 2'b00};
                        state_d         = S_L0_REQ;
                    end else begin
                        resp_valid_d = 1'b1;
                        resp_fault_d = l1_fault;
                        resp_super_d = !pte_bad && !pte_misaligned;
                        resp_ppn_d   = l1_fault ? '0 : {pte_ppn[PPN_WIDTH-1:IDX_W], vpn_lo_q};
                        resp_perm_d  = l1_fault ? '0 : pte_perm;
                        state_d      = S_RESPOND;
                    end
                end
            end
            S_L0_WAIT: begin
                if (mem_resp_valid_i) begin
                    mem_resp_ready_d = 1'b0;
                    resp_valid_d     = 1'b1;
                    resp_fault_d     = l0_fault;
                    resp_super_d     = 1'b0;
                    resp_ppn_d       = l0_fault ? '0 : pte_ppn;
                    resp_perm_d      = l0_fault ? '0 : pte_perm;
                    state_d          = S_RESPOND;
                end
            end
            S_RESPOND: begin
                if (ptw_resp_ready_i) begin
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= S_IDLE;
            vpn_lo_q         <= '0;
            req_ready_q      <= 1'b1;
            resp_valid_q     <= 1'b0;
            resp_ppn_q       <= '0;
            resp_perm_q      <= '0;
            resp_super_q     <= 1'b0;
            resp_fault_q     <= 1'b0;
            mem_req_valid_q  <= 1'b0;
            mem_req_addr_q   <= '0;
            mem_resp_ready_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            vpn_lo_q         <= vpn_lo_d;
            req_ready_q      <= req_ready_d;
            resp_valid_q     <= resp_valid_d;
            resp_ppn_q       <= resp_ppn_d;
            resp_perm_q      <= resp_perm_d;
            resp_super_q     <= resp_super_d;
            resp_fault_q     <= resp_fault_d;
            mem_req_valid_q  <= mem_req_valid_d;
            mem_req_addr_q   <= mem_req_addr_d;
            mem_resp_ready_q <= mem_resp_ready_d;
        end
    end

    assign ptw_req_ready_o  = req_ready_q;
    assign ptw_resp_valid_o = resp_valid_q;
    assign ptw_resp_ppn_o   = resp_ppn_q;
    assign ptw_resp_perm_o  = resp_perm_q;
    assign ptw_resp_super_o = resp_super_q;
    assign ptw_resp_fault_o = resp_fault_q;
    assign mem_req_valid_o  = mem_req_valid_q;
    assign mem_req_addr_o   = mem_req_addr_q;
    assign mem_resp_ready_o = mem_resp_ready_q;

endmodule

// File: tb/tb_ptw_walker.sv
// Testbench for ptw_walker: a PTE memory model and a response monitor act as
// the scoreboard consumers; each test task drives walks and checks results.
module tb_ptw_walker;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] root_ppn_i = '0;
    logic        ptw_req_valid_i = 1'b0;
    logic        ptw_req_ready_o;
    logic [19:0] ptw_req_vpn_i = '0;
    logic        ptw_resp_valid_o;
    logic        ptw_resp_ready_i = 1'b0;
    logic [19:0] ptw_resp_ppn_o;
    logic [3:0]  ptw_resp_perm_o;
    logic        ptw_resp_super_o;
    logic        ptw_resp_fault_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i = 1'b0;
    logic [31:0] mem_req_addr_o;
    logic        mem_resp_valid_i = 1'b0;
    logic        mem_resp_ready_o;
    logic [31:0] mem_resp_data_i = '0;

    ptw_walker #(.VPN_WIDTH(20), .PPN_WIDTH(20), .PTE_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .root_ppn_i(root_ppn_i),
        .ptw_req_valid_i(ptw_req_valid_i), .ptw_req_ready_o(ptw_req_ready_o),
        .ptw_req_vpn_i(ptw_req_vpn_i),
        .ptw_resp_valid_o(ptw_resp_valid_o), .ptw_resp_ready_i(ptw_resp_ready_i),
        .ptw_resp_ppn_o(ptw_resp_ppn_o), .ptw_resp_perm_o(ptw_resp_perm_o),
        .ptw_resp_super_o(ptw_resp_super_o), .ptw_resp_fault_o(ptw_resp_fault_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_addr_o(mem_req_addr_o),
        .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_ready_o(mem_resp_ready_o),
        .mem_resp_data_i(mem_resp_data_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [19:0] ppn;
        logic [3:0]  perm;
        logic        sup;
        logic        fault;
    } resp_t;

    resp_t       exp_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] pte_mem [logic [31:0]];

    int errors = 0;
    int checks = 0;
    int reads = 0;
    int resp_count = 0;
    int mem_stall = 0;
    int resp_stall = 0;
    bit hold_en = 1'b0;
    logic [31:0] hold_addr = '0;
    int mstate = 0;

    function automatic logic [31:0] pte_at(input logic [31:0] a);
        if (pte_mem.exists(a)) return pte_mem[a];
        return '0;
    endfunction

    // PTE memory: optional request stall, checks read addresses against the queue.
    initial begin : mem_model
        logic [31:0] maddr;
        int mcnt;
        forever begin
            @(negedge clk);
            if (rst) begin
                mstate = 0; mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0;
            end else begin
                case (mstate)
                    0: begin
                        mem_resp_valid_i = 1'b0;
                        if (mem_req_valid_o) begin
                            maddr = mem_req_addr_o;
                            mcnt  = mem_stall;
                            if (mcnt == 0) begin mem_req_ready_i = 1'b1; mstate = 1; end
                            else mstate = 2;
                        end
                    end
                    2: begin
                        checks++;
                        if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== maddr || ptw_req_ready_o !== 1'b0) begin
                            errors++;
                            $display("FAIL mem_req_stable: valid=%b addr=%h req_ready=%b, required 1 %h 0",
                                     mem_req_valid_o, mem_req_addr_o, ptw_req_ready_o, maddr);
                        end
                        mcnt--;
                        if (mcnt == 0) begin mem_req_ready_i = 1'b1; mstate = 1; end
                    end
                    1: begin
                        mem_req_ready_i = 1'b0;
                        reads++;
                        checks++;
                        if (exp_addr_q.size() == 0) begin
                            errors++;
                            $display("FAIL mem_addr: unexpected read of %h", maddr);
                        end else begin
                            logic [31:0] ea;
                            ea = exp_addr_q.pop_front();
                            if (maddr !== ea) begin
                                errors++;
                                $display("FAIL mem_addr: got %h, required %h", maddr, ea);
                            end
                        end
                        checks++;
                        if (mem_resp_ready_o !== 1'b1) begin
                            errors++;
                            $display("FAIL mem_resp_ready: got %b, required 1", mem_resp_ready_o);
                        end
                        if (hold_en && maddr == hold_addr) mstate = 3;
                        else begin
                            mem_resp_valid_i = 1'b1;
                            mem_resp_data_i  = pte_at(maddr);
                            mstate = 0;
                        end
                    end
                    default: ; // withholding the response until reset
                endcase
            end
        end
    end

    // Response monitor: optional ready stall, pops and compares the expected result.
    initial begin : resp_monitor
        int rs;
        int rcnt;
        resp_t got, ex;
        rs = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rs = 0; ptw_resp_ready_i = 1'b0;
            end else begin
                case (rs)
                    0: if (ptw_resp_valid_o) begin
                        got = '{ppn: ptw_resp_ppn_o, perm: ptw_resp_perm_o,
                                sup: ptw_resp_super_o, fault: ptw_resp_fault_o};
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL resp_unexpected: got %h", got);
                        end else begin
                            ex = exp_q.pop_front();
                            // the level flag carries no defined meaning on a fault
                            if (got.ppn !== ex.ppn || got.perm !== ex.perm || got.fault !== ex.fault ||
                                (!ex.fault && got.sup !== ex.sup)) begin
                                errors++;
                                $display("FAIL resp_payload: ppn=%h perm=%h super=%b fault=%b, required ppn=%h perm=%h super=%b fault=%b",
                                         got.ppn, got.perm, got.sup, got.fault, ex.ppn, ex.perm, ex.sup, ex.fault);
                            end
                        end
                        rcnt = resp_stall;
                        if (rcnt == 0) begin ptw_resp_ready_i = 1'b1; rs = 1; end
                        else rs = 2;
                    end
                    2: begin
                        checks++;
                        if (ptw_resp_valid_o !== 1'b1 || ptw_req_ready_o !== 1'b0 || ptw_resp_ppn_o !== got.ppn ||
                            ptw_resp_perm_o !== got.perm || ptw_resp_super_o !== got.sup || ptw_resp_fault_o !== got.fault) begin
                            errors++;
                            $display("FAIL resp_stable: valid=%b req_ready=%b ppn=%h, required 1 0 %h",
                                     ptw_resp_valid_o, ptw_req_ready_o, ptw_resp_ppn_o, got.ppn);
                        end
                        rcnt--;
                        if (rcnt == 0) begin ptw_resp_ready_i = 1'b1; rs = 1; end
                    end
                    default: begin
                        ptw_resp_ready_i = 1'b0;
                        resp_count++;
                        checks++;
                        if (ptw_resp_valid_o !== 1'b0 || ptw_req_ready_o !== 1'b1) begin
                            errors++;
                            $display("FAIL resp_done: valid=%b req_ready=%b, required 0 1",
                                     ptw_resp_valid_o, ptw_req_ready_o);
                        end
                        rs = 0;
                    end
                endcase
            end
        end
    end

    // Drives one request; reports cycles to ptw_resp_valid_o, completion and read count.
    task automatic do_walk(input logic [19:0] vpn, input logic [19:0] root,
                           output int lat, output bit done, output int nreads);
        int r0, c0, n;
        r0 = reads; c0 = resp_count;
        @(negedge clk);
        ptw_req_vpn_i = vpn; root_ppn_i = root; ptw_req_valid_i = 1'b1;
        @(negedge clk);
        ptw_req_valid_i = 1'b0;
        lat = 1;
        while (!ptw_resp_valid_o && lat < 300) begin @(negedge clk); lat++; end
        n = 0;
        while (resp_count == c0 && n < 300) begin @(negedge clk); n++; end
        done = (resp_count != c0);
        nreads = reads - r0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++;
        if (ptw_req_ready_o !== 1'b1 || ptw_resp_valid_o !== 1'b0 || mem_req_valid_o !== 1'b0 || mem_resp_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: req_ready=%b resp_valid=%b mem_req_valid=%b mem_resp_ready=%b, required 1 0 0 0",
                     ptw_req_ready_o, ptw_resp_valid_o, mem_req_valid_o, mem_resp_ready_o);
        end
        checks++;
        if (ptw_resp_ppn_o !== '0 || ptw_resp_perm_o !== '0 || ptw_resp_super_o !== 1'b0 ||
            ptw_resp_fault_o !== 1'b0 || mem_req_addr_o !== '0) begin
            errors++;
            $display("FAIL reset_data: ppn=%h perm=%h super=%b fault=%b addr=%h, required all zero",
                     ptw_resp_ppn_o, ptw_resp_perm_o, ptw_resp_super_o, ptw_resp_fault_o, mem_req_addr_o);
        end
        #2 rst = 1'b0;
    endtask

    task automatic test_l0_walk;
        int lat, nr; bit done;
        exp_addr_q.push_back(32'h0001_0004);
        exp_addr_q.push_back(32'h0001_1004);
        exp_q.push_back('{ppn: 20'h00053, perm: 4'hF, sup: 1'b0, fault: 1'b0});
        do_walk(20'h00401, 20'h00010, lat, done, nr);
        checks++;
        if (!done) begin errors++; $display("FAIL l0_done: walk did not complete within budget"); end
        checks++;
        if (lat != 5) begin errors++; $display("FAIL l0_latency: got %0d, required 5", lat); end
        checks++;
        if (nr != 2) begin errors++; $display("FAIL l0_reads: got %0d, required 2", nr); end
    endtask

    task automatic test_superpage;
        int lat, nr; bit done;
        exp_addr_q.push_back(32'h0001_000C);
        exp_q.push_back('{ppn: 20'h80005, perm: 4'h7, sup: 1'b1, fault: 1'b0});
        do_walk(20'h00C05, 20'h00010, lat, done, nr);
        checks++;
        if (!done) begin errors++; $display("FAIL super_done: walk did not complete within budget"); end
        checks++;
        if (lat != 3) begin errors++; $display("FAIL super_latency: got %0d, required 3", lat); end
        checks++;
        if (nr != 1) begin errors++; $display("FAIL super_reads: got %0d, required 1", nr); end
    endtask

    task automatic test_faults;
        int lat, nr; bit done;
        // misaligned superpage, invalid L1, non-leaf at L0
        logic [19:0] vpns [3]  = '{20'h00801, 20'h01402, 20'h01803};
        int          nreads[3] = '{1, 1, 2};
        exp_addr_q.push_back(32'h0001_0008);
        exp_addr_q.push_back(32'h0001_0014);
        exp_addr_q.push_back(32'h0001_0018);
        exp_addr_q.push_back(32'h0001_200C);
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{ppn: 20'h0, perm: 4'h0, sup: 1'b0, fault: 1'b1});
            do_walk(vpns[i], 20'h00010, lat, done, nr);
            checks++;
            if (!done || nr != nreads[i]) begin
                errors++;
                $display("FAIL fault_walk%0d: done=%b reads=%0d, required 1 %0d", i, done, nr, nreads[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        int lat, nr; bit done;
        mem_stall = 5; resp_stall = 3;
        exp_addr_q.push_back(32'h0001_0004);
        exp_addr_q.push_back(32'h0001_1004);
        exp_q.push_back('{ppn: 20'h00053, perm: 4'hF, sup: 1'b0, fault: 1'b0});
        do_walk(20'h00401, 20'h00010, lat, done, nr);
        checks++;
        if (!done || nr != 2) begin
            errors++;
            $display("FAIL bp_walk: done=%b reads=%0d, required 1 2", done, nr);
        end
        mem_stall = 0; resp_stall = 0;
    endtask

    task automatic test_reset_mid_walk;
        int n, lat, nr; bit done;
        hold_en = 1'b1; hold_addr = 32'h0001_1004;
        exp_addr_q.push_back(32'h0001_0004);
        exp_addr_q.push_back(32'h0001_1004);
        @(negedge clk);
        ptw_req_vpn_i = 20'h00401; root_ppn_i = 20'h00010; ptw_req_valid_i = 1'b1;
        @(negedge clk);
        ptw_req_valid_i = 1'b0;
        n = 0;
        while (mstate != 3 && n < 300) begin @(negedge clk); n++; end
        checks++;
        if (mstate != 3) begin errors++; $display("FAIL rst_reach_l0: L0 read not seen within budget"); end
        @(negedge clk);
        checks++;
        if (mem_resp_ready_o !== 1'b1) begin
            errors++; $display("FAIL rst_l0_wait: mem_resp_ready=%b, required 1", mem_resp_ready_o);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (ptw_resp_valid_o !== 1'b0 || mem_req_valid_o !== 1'b0 || mem_resp_ready_o !== 1'b0 || ptw_req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_abort: resp_valid=%b mem_req_valid=%b mem_resp_ready=%b req_ready=%b, required 0 0 0 1",
                     ptw_resp_valid_o, mem_req_valid_o, mem_resp_ready_o, ptw_req_ready_o);
        end
        exp_q.delete();
        exp_addr_q.delete();
        hold_en = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        exp_addr_q.push_back(32'h0001_000C);
        exp_q.push_back('{ppn: 20'h80005, perm: 4'h7, sup: 1'b1, fault: 1'b0});
        do_walk(20'h00C05, 20'h00010, lat, done, nr);
        checks++;
        if (!done || lat != 3 || nr != 1) begin
            errors++;
            $display("FAIL rst_recover: done=%b latency=%0d reads=%0d, required 1 3 1", done, lat, nr);
        end
    endtask

    initial begin
        pte_mem[32'h0001_0004] = 32'h0000_4401;
        pte_mem[32'h0001_1004] = 32'h0001_4C1F;
        pte_mem[32'h0001_000C] = 32'h2000_00CF;
        pte_mem[32'h0001_0008] = 32'h0000_040F;
        pte_mem[32'h0001_0018] = 32'h0000_4801;
        pte_mem[32'h0001_200C] = 32'h0000_0401;
        test_reset();
        test_l0_walk();
        test_superpage();
        test_faults();
        test_backpressure();
        test_reset_mid_walk();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || exp_addr_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d responses and %0d reads outstanding, required 0 0",
                     exp_q.size(), exp_addr_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ptw_walker.md
Name: ptw_walker

Overview:
- Page-table-walk responder at the far end of the TLB-to-PTW handshake. It accepts a one-VPN translation-miss request from the TLB controller and performs a two-level Sv32-style walk over a single-outstanding memory read port.
- It returns the PPN, permission bits, page level and a fault flag on the PTW response channel.
- Sits between the TLB controller and the memory/cache read port.

Parameters:
- VPN_WIDTH, 20, virtual page number width; two 10-bit indices (VPN[19:10]=L1, VPN[9:0]=L0).
- PPN_WIDTH, 20, physical page number width.
- PTE_WIDTH, 32, page table entry width.
- ADDR_WIDTH, 32, memory byte address width; must equal PPN_WIDTH+12.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- root_ppn_i  in  PPN_WIDTH  root page-table PPN; sampled at request accept
- ptw_req_valid_i  in  1  TLB miss request valid
- ptw_req_ready_o  out  1  walker can accept a request
- ptw_req_vpn_i  in  VPN_WIDTH  VPN to translate
- ptw_resp_valid_o  out  1  walk result valid
- ptw_resp_ready_i  in  1  TLB accepts result
- ptw_resp_ppn_o  out  PPN_WIDTH  translated PPN
- ptw_resp_perm_o  out  4  {U,X,W,R} from leaf PTE
- ptw_resp_super_o  out  1  leaf found at L1 (4 MiB page)
- ptw_resp_fault_o  out  1  page fault
- mem_req_valid_o  out  1  PTE read request valid
- mem_req_ready_i  in  1  memory accepts request
- mem_req_addr_o  out  ADDR_WIDTH  PTE byte address
- mem_resp_valid_i  in  1  PTE data valid
- mem_resp_ready_o  out  1  walker accepts PTE data
- mem_resp_data_i  in  PTE_WIDTH  PTE data

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is asynchronous and active-high. All outputs are registered.
- Reset values: ptw_req_ready_o=1. ptw_resp_valid_o, mem_req_valid_o and mem_resp_ready_o are 0. All data outputs are 0. State is IDLE.
- PTE fields: V=bit0, R=1, W=2, X=3, U=4, A=6, D=7. PPN is PTE[29:10].
- States: IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, RESPOND.
- IDLE: on ptw_req_valid_i && ptw_req_ready_o, latch vpn and root_ppn_i, drop ready, go to L1_REQ. mem_req_valid_o rises the next cycle.
- L1_REQ: mem_req_addr_o={root_ppn, vpn[19:10], 2'b00}. Hold valid and address stable until mem_req_ready_i, then go to L1_WAIT with mem_resp_ready_o=1.
- L1_WAIT: on mem_resp_valid_i, capture the PTE and classify it:
  - !V, or (W && !R): fault.
  - Leaf (R||X) with PTE PPN[9:0]!=0: misaligned superpage, fault.
  - Leaf, aligned: ppn={pte_ppn[19:10], vpn[9:0]}, super=1.
  - Non-leaf: go to L0_REQ with address {pte_ppn, vpn[9:0], 2'b00}.
- L0_REQ / L0_WAIT: same handshake as L1. At L0, !V, W&&!R, or a non-leaf PTE is a fault. A leaf gives ppn=pte_ppn, super=0.
- RESPOND: ptw_resp_valid_o=1 with all payload stable until ptw_resp_ready_i. Then drop valid, set ptw_req_ready_o=1 and go to IDLE.
- On fault: ppn=0 and perm=0 are driven.
- Latency, L1 leaf with zero-wait memory: request accept at cycle T, mem_req at T+1, response data at T+2, ptw_resp_valid_o at T+3. An L0 walk adds 2 cycles.
- Single outstanding request only. ptw_req_ready_o is 0 from accept until the response handshake completes.
- mem_resp_valid_i outside the WAIT states is ignored. mem_resp_ready_o is 0 outside WAIT states.
- ptw_req_valid_i held high during RESPOND is not accepted until the cycle after the response handshake, when ready re-asserts.
- Reset mid-walk aborts immediately to IDLE and deasserts all valids. Memory is reset in the same domain, so no stale response is expected.
- Back-pressure of any duration on mem_req_ready_i or ptw_resp_ready_i holds state with no change in outputs.

Optional Feature:
- PTW_AD_CHECK_EN defined: a leaf PTE with A=0 is reported as a fault (ppn=0, perm=0, super reflects the level at which the leaf was found).
- Undefined: A and D bits are ignored.

Test Plan:
- root_ppn=0x00010, vpn=0x00401. L1 PTE=0x0000_4401 (non-leaf, ppn 0x00011). L0 PTE=0x0001_4C1F at addr 0x00011004 -> L1 addr 0x00010004, resp ppn=0x00053, perm=0xF, super=0, fault=0.
- vpn=0x00C05, L1 PTE=0x2000_00CF (leaf, ppn 0x80000 aligned) -> ppn=0x80005, super=1, fault=0, one memory read only.
- L1 PTE=0x0000_040F (leaf, ppn[9:0]=1) -> fault=1, ppn=0, perm=0.
- L1 PTE=0x0 (V=0) -> fault after one read. Separately, L0 PTE non-leaf 0x0000_0401 -> fault=1.
- mem_req_ready_i low for 5 cycles and ptw_resp_ready_i low for 3 cycles -> address/valid and response payload stable throughout; ptw_req_ready_o stays 0 until the final handshake.
- Assert rst during L0_WAIT -> next cycle all valids are 0 and ptw_req_ready_o=1. A new request then completes normally.
